// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared state encoding and default widths for the counter_ctrl block.
`default_nettype none

package counter_ctrl_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_WRAP_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/counter_ctrl_if.sv
// counter_ctrl_if: command, config and status bundle between the control logic and counter_ctrl.
`default_nettype none

interface counter_ctrl_if
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int WRAP_W = DEF_WRAP_W
);

  logic              cfg_valid;
  logic              cfg_ready;
  logic [WIDTH-1:0]  cfg_limit;
  logic              cfg_periodic;
  logic              start;
  logic              stop;
  logic              clear;
  logic [WIDTH-1:0]  count;
  logic              busy;
  logic              match_pulse;
  logic              done;
  logic [WRAP_W-1:0] wrap_cnt;

  modport master (
    output cfg_valid, cfg_limit, cfg_periodic, start, stop, clear,
    input  cfg_ready, count, busy, match_pulse, done, wrap_cnt
  );

  modport slave (
    input  cfg_valid, cfg_limit, cfg_periodic, start, stop, clear,
    output cfg_ready, count, busy, match_pulse, done, wrap_cnt
  );

endinterface

`default_nettype wire

// File: rtl/counter_ctrl_core.sv
// counter_core: WIDTH-bit up-counter with async reset, clear, load-zero, increment enable and limit compare.
`default_nettype none

module counter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_zero_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] count_o,
  output logic             eq_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i || load_zero_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign eq_o    = (count_q == limit_i);

endmodule

`default_nettype wire

// File: rtl/counter_ctrl.sv
// counter_ctrl: start/stop/clear sequencer with compare limit, one-shot/periodic modes and wrap count.
// Optional prescaler enabled by defining COUNTER_CTRL_PRESCALE_EN.
`default_nettype none

module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int WRAP_W = DEF_WRAP_W
) (
  input  logic                clk,
  input  logic                rst,
`ifdef COUNTER_CTRL_PRESCALE_EN
  input  logic [7:0]          prescale,
`endif
  counter_ctrl_if.slave       bus
);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    limit_q, limit_d;
  logic                periodic_q, periodic_d;
  logic [WRAP_W-1:0]   wrap_q, wrap_d;
  logic                match_q, match_d;

  logic                core_clr, core_zero, core_inc, core_eq;
  logic [WIDTH-1:0]    core_count;
  logic                cfg_ready;
  logic                cfg_acc;
  logic                tick;

  counter_core #(.WIDTH(WIDTH)) u_core (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (core_clr),
    .load_zero_i (core_zero),
    .inc_i       (core_inc),
    .limit_i     (limit_q),
    .count_o     (core_count),
    .eq_o        (core_eq)
  );

  assign cfg_ready = (state_q == IDLE) || (state_q == DONE);
  assign cfg_acc   = bus.cfg_valid && cfg_ready;

`ifdef COUNTER_CTRL_PRESCALE_EN
  logic [7:0] presc_q, presc_d;
  logic       presc_zero;

  assign tick       = (presc_q == prescale);
  assign presc_zero = bus.clear || cfg_acc || (bus.start && cfg_ready);

  // A stop without a tick freezes the prescaler so PAUSE resumes mid-period.
  always_comb begin
    presc_d = presc_q;
    if (presc_zero || (state_q == RUN && tick)) begin
      presc_d = '0;
    end else if (state_q == RUN && !bus.stop) begin
      presc_d = presc_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    periodic_d = periodic_q;
    wrap_d     = wrap_q;
    match_d    = 1'b0;
    core_clr   = 1'b0;
    core_zero  = 1'b0;
    core_inc   = 1'b0;

    if (bus.clear) begin
      state_d  = IDLE;
      core_clr = 1'b1;
      wrap_d   = '0;
    end else if (cfg_acc) begin
      state_d    = IDLE;
      limit_d    = bus.cfg_limit;
      periodic_d = bus.cfg_periodic;
      core_zero  = 1'b1;
      wrap_d     = '0;
    end else begin
      case (state_q)
        RUN: begin
          // The match is handled before a coincident stop is honoured.
          if (tick && core_eq) begin
            match_d = 1'b1;
            if (periodic_q) begin
              core_zero = 1'b1;
              if (wrap_q != '1) begin
                wrap_d = wrap_q + WRAP_W'(1);
              end
              if (bus.stop) begin
                state_d = PAUSE;
              end
            end else begin
              state_d = DONE;
            end
          end else if (bus.stop) begin
            state_d = PAUSE;
          end else if (tick) begin
            core_inc = 1'b1;
          end
        end
        PAUSE: begin
          if (bus.start) begin
            state_d = RUN;
          end
        end
        default: begin
          if (bus.start) begin
            state_d   = RUN;
            core_zero = 1'b1;
            wrap_d    = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      limit_q    <= '1;
      periodic_q <= 1'b0;
      wrap_q     <= '0;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      periodic_q <= periodic_d;
      wrap_q     <= wrap_d;
      match_q    <= match_d;
    end
  end

  assign bus.cfg_ready   = cfg_ready;
  assign bus.count       = core_count;
  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.match_pulse = match_q;
  assign bus.wrap_cnt    = wrap_q;

endmodule

`default_nettype wire

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
- Sequencing controller for a free-running-style up-counter datapath.
- Adds configuration, start/stop/clear control, a compare limit, one-shot or periodic modes, a match pulse and a wrap count.
- Sits between the control logic, which issues commands and config, and the counter register, so software-like sequencing can reuse one counter as a timer.

Parameters:
- WIDTH, 32, counter and limit width in bits.
- WRAP_W, 8, width of the saturating wrap counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- cfg_valid  input  1  config request.
- cfg_ready  output  1  config accepted this cycle when cfg_valid && cfg_ready.
- cfg_limit  input  WIDTH  compare limit; match when count == limit.
- cfg_periodic  input  1  1 = periodic (auto-restart), 0 = one-shot.
- start  input  1  start or resume command, 1-cycle level sample.
- stop  input  1  pause command.
- clear  input  1  abort to IDLE, zero the count.
- count  output  WIDTH  current counter value (registered).
- busy  output  1  high in RUN.
- match_pulse  output  1  1-cycle pulse on each limit match.
- done  output  1  high in DONE.
- wrap_cnt  output  WRAP_W  number of periodic wraps, saturating.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, count=0, limit_q=all-ones, periodic_q=0, match_pulse=0, wrap_cnt=0.
  - Outputs derived from state: busy=0, done=0, cfg_ready=1.
- States: IDLE, RUN, PAUSE, DONE. busy=(RUN), done=(DONE), cfg_ready=(IDLE|DONE).
- Command priority per cycle: clear > cfg accept > stop > start.
- clear, any state: next state=IDLE, count=0, wrap_cnt=0, match_pulse=0. limit_q and periodic_q are kept.
- cfg accept (IDLE/DONE only):
  - limit_q<=cfg_limit, periodic_q<=cfg_periodic, count<=0, wrap_cnt<=0, state<=IDLE.
  - cfg_valid in RUN/PAUSE is not accepted. The requester holds it until cfg_ready=1.
- start:
  - IDLE/DONE -> RUN, count<=0, wrap_cnt<=0.
  - PAUSE -> RUN, count kept.
  - Ignored in RUN.
- stop: RUN -> PAUSE, count held. Ignored elsewhere.
- RUN tick (every cycle; see Optional Feature):
  - If count==limit_q: match_pulse<=1.
    - periodic_q=1: count<=0, wrap_cnt<=wrap_cnt+1, saturating at all-ones.
    - periodic_q=0: state<=DONE, count held at limit_q.
  - Else: count<=count+1, modulo 2^WIDTH. Unreachable past limit_q.
- match_pulse is registered. It is high exactly one cycle, the cycle after the edge at which the match was evaluated. It is 0 in all other cycles.
- Latency:
  - start sampled at edge N -> RUN with count=0 after N.
  - count=1 after N+1.
  - First match at limit L: evaluated at edge N+L+1; match_pulse high after that edge.
- limit_q=0: match on every tick. Periodic mode gives match_pulse continuously high, count stays 0, and wrap_cnt increments each cycle. One-shot goes to DONE after one tick.
- Simultaneous stop and match in RUN:
  - Match is processed first (pulse, wrap/DONE).
  - Periodic: then PAUSE with count=0.
  - One-shot: DONE; stop ignored.
- Simultaneous start and stop in RUN: stop wins -> PAUSE. In PAUSE: stop is ignored, start resumes.
- rst asserted mid-RUN: immediate return to reset values, no match_pulse.

Optional Feature:
- Macro COUNTER_CTRL_PRESCALE_EN.
- Defined:
  - Adds input port prescale [7:0] and an internal 8-bit prescaler. A RUN tick occurs only when the prescaler == prescale, then the prescaler reloads to 0.
  - The prescaler is zeroed on rst, clear, cfg accept and start-from-IDLE/DONE. It is held in PAUSE.
  - prescale=0 is equivalent to no prescaling.
- Undefined: no prescale port; tick every RUN cycle.

Decomposition:
- Shared package counter_ctrl_pkg holds the state enum (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3) and default widths (WIDTH=32, WRAP_W=8).
- Natural sub-module counter_core: WIDTH-bit register with async rst, clear, load-zero and increment-enable. It outputs count and an eq flag for count==limit.
- FSM, wrap counter and prescaler stay in counter_ctrl.

Test Plan:
- One-shot limit 5: cfg (limit=5, periodic=0) then start.
  - count goes 0..5; match_pulse high one cycle at the 6th tick.
  - done=1, count stays 5; a second start restarts from 0.
- Periodic limit 3, run 12 ticks: count sequence 0,1,2,3,0,1,2,3,0,...; 3 match pulses; wrap_cnt=3.
- Pause/resume at limit 10: stop at count=4 holds 4 for 5 cycles; start resumes 5,6,...; match at 10.
- Priority: clear+start+cfg_valid together in RUN -> IDLE, count=0, cfg not accepted. Next cycle cfg_ready=1 and cfg accepted.
- Boundaries:
  - periodic limit=0 gives match_pulse high each cycle and wrap_cnt saturating at 255 after 255 ticks.
  - Async rst mid-RUN clears all outputs without waiting for clk.
- With COUNTER_CTRL_PRESCALE_EN and prescale=2, limit=2: count increments every 3 cycles; match_pulse on the 9th cycle after RUN entry.
